fifo_write_arbiter: RTL and testbench

- Single-clock round-robin arbiter that shares one FIFO write port among `NUM_REQ` producers.
- Grants the port to one requester at a time for a burst of up to `MAX_BURST` beats, then rotates priority.
- Stalls cleanly on FIFO full.
- Sits directly in front of the FIFO's `buf_in` / `wr_en` / `buf_full` interface. The FIFO's own pointers and counter are unchanged by this block.

---
 rtl/fifo_write_arbiter.sv | 131 +++++++++++++
 tb/tb_fifo_write_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Each owner keeps the port for up to MAX_BURST beats; a FIFO-full stall never forces a release.
module fifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic [NUM_REQ-1:0]          grant,
    output logic [$clog2(NUM_REQ)-1:0]  owner,
    output logic                        busy,
    input  logic                        buf_full,
    output logic [DATA_W-1:0]           buf_in,
    output logic                        wr_en
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [IDX_W-1:0]     r_owner;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [CNT_W-1:0]     r_beat_cnt;

    logic [DATA_W-1:0]    w_data [NUM_REQ];
    logic                 w_owner_req;
    logic                 w_beat;
    logic                 w_release;
    logic [IDX_W-1:0]     w_next_ptr;
    logic [IDX_W-1:0]     w_arb_ptr;
    logic [IDX_W-1:0]     w_pick;
    logic                 w_pick_valid;
    logic [NUM_REQ-1:0]   w_pick_onehot;
    int                   w_scan_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign w_data[gi] = req_data[gi*DATA_W +: DATA_W];
            assign ack[gi]    = r_grant[gi] & wr_en;
        end
    endgenerate

    assign grant       = r_grant;
    assign owner       = r_owner;
    assign busy        = |r_grant;
    assign w_owner_req = req[r_owner];
    assign wr_en       = busy & w_owner_req & ~buf_full;
    assign buf_in      = busy ? w_data[r_owner] : '0;
    assign w_beat      = wr_en;
    assign w_release   = (w_beat && (r_beat_cnt == LAST_BEAT)) || !w_owner_req;

    // While granted, arbitration always looks past the current owner so a release
    // can hand over in the same cycle with the outgoing owner at lowest priority.
    assign w_next_ptr  = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
    assign w_arb_ptr   = (r_state == ST_GRANT) ? w_next_ptr : r_rr_ptr;

    // Reverse scan so the nearest asserted request from w_arb_ptr is the last one written.
    always_comb begin
        w_pick       = '0;
        w_pick_valid = 1'b0;
        w_scan_idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_scan_idx = int'(w_arb_ptr) + k;
            if (w_scan_idx >= NUM_REQ) begin
                w_scan_idx = w_scan_idx - NUM_REQ;
            end
            if (req[w_scan_idx]) begin
                w_pick       = IDX_W'(w_scan_idx);
                w_pick_valid = 1'b1;
            end
        end
    end

    assign w_pick_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_state    <= ST_GRANT;
                        r_grant    <= w_pick_onehot;
                        r_owner    <= w_pick;
                        r_beat_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_rr_ptr   <= w_next_ptr;
                        r_beat_cnt <= '0;
                        if (w_pick_valid) begin
                            r_grant <= w_pick_onehot;
                            r_owner <= w_pick;
                        end else begin
                            r_state <= ST_IDLE;
                            r_grant <= '0;
                            r_owner <= '0;
                        end
                    end else if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_owner <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: expected beats are queued per scenario
// and matched against every wr_en cycle.
module tb_fifo_write_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic [NUM_REQ-1:0]        grant;
    logic [1:0]                owner;
    logic                      busy;
    logic                      buf_full = 1'b0;
    logic [DATA_W-1:0]         buf_in;
    logic                      wr_en;

    logic [7:0] data [NUM_REQ];
    assign req_data = {data[3], data[2], data[1], data[0]};

    typedef struct packed {
        logic [1:0] own;
        logic [7:0] dat;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    logic       tk_we;
    logic [3:0] tk_ack;

    fifo_write_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_data(req_data),
        .ack     (ack),
        .grant   (grant),
        .owner   (owner),
        .busy    (busy),
        .buf_full(buf_full),
        .buf_in  (buf_in),
        .wr_en   (wr_en)
    );

    always #5 clk = ~clk;

    task automatic push_burst(input int own, input int first, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(beat_t'{own[1:0], 8'(first + k)});
        end
    endtask

    // One cycle: observe at the falling edge, retire any beat against the scoreboard,
    // then advance acknowledged requesters just after the rising edge.
    task automatic tick(output logic we_o, output logic [3:0] ack_o);
        beat_t e;
        @(negedge clk);
        we_o  = wr_en;
        ack_o = ack;
        if (wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL beat_unexpected owner=%0d data=%02h required=no_write", owner, buf_in);
            end else begin
                e = exp_q.pop_front();
                if (owner !== e.own || buf_in !== e.dat || ack !== (4'b0001 << e.own)) begin
                    failures++;
                    $display("FAIL beat owner=%0d data=%02h ack=%b required owner=%0d data=%02h ack=%b",
                             owner, buf_in, ack, e.own, e.dat, 4'b0001 << e.own);
                end else begin
                    $display("beat owner=%0d data=%02h ack=%b", owner, buf_in, ack);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ack_o[i]) data[i] = data[i] + 8'd1;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        req      = '0;
        buf_full = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        req = 4'b1111;
        #2;
        checks++;
        if (grant !== 4'b0 || owner !== 2'd0 || busy !== 1'b0 || wr_en !== 1'b0 || ack !== 4'b0 || buf_in !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs grant=%b owner=%0d busy=%b wr_en=%b ack=%b buf_in=%02h required all zero",
                     grant, owner, busy, wr_en, ack, buf_in);
        end
        @(posedge clk);
        #1;
        checks++;
        if (grant !== 4'b0 || dut.r_rr_ptr !== 2'd0 || dut.r_beat_cnt !== 3'd0) begin
            failures++;
            $display("FAIL reset_held grant=%b rr_ptr=%0d beat_cnt=%0d required 0/0/0",
                     grant, dut.r_rr_ptr, dut.r_beat_cnt);
        end
        req = '0;
        rst = 1'b1;
        $display("reset released");
    endtask

    task automatic test_lone();
        data[0] = 8'h10;
        push_burst(0, 'h10, 6);
        req = 4'b0001;
        tick(tk_we, tk_ack);
        checks++;
        if (tk_we !== 1'b0) begin
            failures++;
            $display("FAIL lone_latency wr_en=%b required 0", tk_we);
        end
        for (int k = 0; k < 6; k++) begin
            tick(tk_we, tk_ack);
            checks++;
            if (tk_we !== 1'b1) begin
                failures++;
                $display("FAIL lone_stream beat=%0d wr_en=%b required 1", k, tk_we);
            end
        end
        req = '0;
        tick(tk_we, tk_ack);
        checks++;
        if (tk_we !== 1'b0 || grant !== 4'b0) begin
            failures++;
            $display("FAIL lone_release wr_en=%b grant=%b required 0/0000", tk_we, grant);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL lone_drain left=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_burst();
        data[2] = 8'h20;
        push_burst(2, 'h20, 2);
        req = 4'b0100;
        repeat (3) tick(tk_we, tk_ack);
        checks++;
        if (grant !== 4'b0100 || dut.r_beat_cnt !== 3'd2) begin
            failures++;
            $display("FAIL midburst_setup grant=%b beat_cnt=%0d required 0100/2", grant, dut.r_beat_cnt);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0 || wr_en !== 1'b0 || owner !== 2'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midburst_async grant=%b wr_en=%b owner=%0d busy=%b required 0000/0/0/0",
                     grant, wr_en, owner, busy);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        push_burst(2, 'h22, 4);
        tick(tk_we, tk_ack);
        checks++;
        if (tk_we !== 1'b0 || grant !== 4'b0100) begin
            failures++;
            $display("FAIL midburst_regrant wr_en=%b grant=%b required 0/0100", tk_we, grant);
        end
        repeat (3) tick(tk_we, tk_ack);
        checks++;
        if (dut.r_beat_cnt !== 3'd3 || dut.r_rr_ptr !== 2'd0) begin
            failures++;
            $display("FAIL midburst_fresh beat_cnt=%0d rr_ptr=%0d required 3/0", dut.r_beat_cnt, dut.r_rr_ptr);
        end
        tick(tk_we, tk_ack);
        checks++;
        if (dut.r_rr_ptr !== 2'd3 || grant !== 4'b0100) begin
            failures++;
            $display("FAIL midburst_rotate rr_ptr=%0d grant=%b required 3/0100", dut.r_rr_ptr, grant);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL midburst_drain left=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Continues from requester 2 owning the port with rr_ptr already at 3.
    task automatic test_priority_wrap();
        data[0] = 8'hA0;
        data[1] = 8'h30;
        push_burst(0, 'hA0, 4);
        push_burst(1, 'h30, 4);
        req = 4'b0011;
        tick(tk_we, tk_ack);
        checks++;
        if (tk_we !== 1'b0 || grant !== 4'b0001 || dut.r_rr_ptr !== 2'd3) begin
            failures++;
            $display("FAIL wrap_pick wr_en=%b grant=%b rr_ptr=%0d required 0/0001/3", tk_we, grant, dut.r_rr_ptr);
        end
        for (int k = 0; k < 8; k++) begin
            tick(tk_we, tk_ack);
            checks++;
            if (tk_we !== 1'b1) begin
                failures++;
                $display("FAIL wrap_stream beat=%0d wr_en=%b required 1", k, tk_we);
            end
        end
        req = '0;
        tick(tk_we, tk_ack);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL wrap_drain left=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_rotation();
        do_reset();
        data[0] = 8'h40;
        data[3] = 8'h50;
        push_burst(0, 'h40, 4);
        push_burst(3, 'h50, 4);
        push_burst(0, 'h44, 4);
        push_burst(3, 'h54, 4);
        req = 4'b1001;
        tick(tk_we, tk_ack);
        for (int k = 0; k < 16; k++) begin
            tick(tk_we, tk_ack);
            checks++;
            if (tk_we !== 1'b1) begin
                failures++;
                $display("FAIL rotation_stream beat=%0d wr_en=%b required 1", k, tk_we);
            end
        end
        req = '0;
        tick(tk_we, tk_ack);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rotation_drain left=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        data[1] = 8'h60;
        push_burst(1, 'h60, 4);
        req = 4'b0010;
        repeat (3) tick(tk_we, tk_ack);
        buf_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(tk_we, tk_ack);
            checks++;
            if (tk_we !== 1'b0 || tk_ack !== 4'b0 || grant !== 4'b0010 || dut.r_beat_cnt !== 3'd2) begin
                failures++;
                $display("FAIL stall cycle=%0d wr_en=%b ack=%b grant=%b beat_cnt=%0d required 0/0000/0010/2",
                         k, tk_we, tk_ack, grant, dut.r_beat_cnt);
            end
        end
        buf_full = 1'b0;
        repeat (2) tick(tk_we, tk_ack);
        checks++;
        if (dut.r_rr_ptr !== 2'd2) begin
            failures++;
            $display("FAIL stall_release rr_ptr=%0d required 2", dut.r_rr_ptr);
        end
        req = '0;
        tick(tk_we, tk_ack);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL stall_drain left=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_early_drop();
        do_reset();
        data[1] = 8'h70;
        data[2] = 8'h80;
        push_burst(1, 'h70, 1);
        push_burst(2, 'h80, 1);
        req = 4'b0110;
        repeat (2) tick(tk_we, tk_ack);
        req = 4'b0100;
        tick(tk_we, tk_ack);
        checks++;
        if (tk_we !== 1'b0 || grant !== 4'b0100 || dut.r_rr_ptr !== 2'd2) begin
            failures++;
            $display("FAIL drop_handover wr_en=%b grant=%b rr_ptr=%0d required 0/0100/2",
                     tk_we, grant, dut.r_rr_ptr);
        end
        tick(tk_we, tk_ack);
        req = '0;
        tick(tk_we, tk_ack);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drop_drain left=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) data[i] = 8'h00;
        test_reset();
        test_lone();
        test_reset_mid_burst();
        test_priority_wrap();
        test_rotation();
        test_full_stall();
        test_early_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time_limit_reached required completion");
        $fatal(1, "watchdog");
    end

endmodule
